// File: rtl/gcm_pkg.sv
// gcm_pkg: types and helpers shared by the AES-GCM datapath buffers
package gcm_pkg;
    localparam int BLOCK_W = 128;

    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        logic               last;
    } gcm_blk_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/gcm_fifo_mem.sv
// gcm_fifo_mem: simple dual-port array, synchronous write, combinational read
module gcm_fifo_mem #(
    parameter int WIDTH   = 129,
    parameter int ENTRIES = 31,
    parameter int AW      = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/gcm_out_fifo.sv
// gcm_out_fifo: output elastic buffer of the AES-GCM core; circular memory
// plus one output register, valid/ready towards the consumer.
module gcm_out_fifo
    import gcm_pkg::*;
#(
    parameter int DATA_WIDTH   = BLOCK_W,
    parameter int DEPTH        = 32,
    parameter int AFULL_MARGIN = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  core_hold,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow
);
    localparam int AW = clog2(DEPTH - 1);
    localparam int LW = clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);

    logic [AW:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH:0] mem_rdata;
    logic mem_empty, mem_full, pop, push, load, wr_en, rd_adv;

    // memory holds DEPTH-1 entries, so the index wraps at DEPTH-2 and flips the wrap bit
    function automatic logic [AW:0] inc(input logic [AW:0] p);
        return (p[AW-1:0] == LAST_IDX) ? {~p[AW], {AW{1'b0}}} : p + 1'b1;
    endfunction

    assign mem_empty = wr_ptr == rd_ptr;
    assign mem_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!(mem_full && out_valid) || pop);
    assign load      = pop || !out_valid;
    assign wr_en     = push && !clear && !(load && mem_empty);
    assign rd_adv    = load && !mem_empty;
    assign core_hold = (LW'(DEPTH) - level) <= LW'(AFULL_MARGIN);

    gcm_fifo_mem #(
        .WIDTH  (DATA_WIDTH + 1),
        .ENTRIES(DEPTH - 1),
        .AW     (AW)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr[AW-1:0]),
        .wdata({in_last, in_data}),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= inc(wr_ptr);
            if (rd_adv) rd_ptr <= inc(rd_ptr);
            // memory head has priority; an empty memory lets the incoming block bypass
            if (load) begin
                out_valid <= !mem_empty || push;
                if (!mem_empty) {out_last, out_data} <= mem_rdata;
                else if (push) {out_last, out_data} <= {in_last, in_data};
            end
            level <= level + LW'(push) - LW'(pop);
            if (in_valid && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gcm_out_fifo.sv
// tb_gcm_out_fifo: randomized and directed checks against a queue reference model
module tb_gcm_out_fifo;
    localparam int DW = 128, DEPTH = 32, MARGIN = 15, LW = 6;

    logic          clk = 0, rst = 0, clear = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic          core_hold, out_valid, out_last, overflow;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;

    logic [DW:0] mq[$];
    bit          m_ovf;
    int          n_checks, n_fail;

    always #5 clk = ~clk;

    gcm_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .core_hold(core_hold), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit l, input bit rdy, input bit clr);
        bit pop, acc;
        in_valid = iv; in_data = d; in_last = l; out_ready = rdy; clear = clr;
        if (clr) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            pop = mq.size() > 0 && rdy;
            acc = iv && (mq.size() < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back({l, d});
            else if (iv) m_ovf = 1;
        end
        @(posedge clk); #1;
        in_valid = 0; clear = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        #12;
        n_checks++;
        if ({out_valid, out_last, overflow, core_hold, level, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b last=%b ovf=%b hold=%b level=%0d data=%h, want all 0",
                     out_valid, out_last, overflow, core_hold, level, out_data);
        end
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        mq.delete(); m_ovf = 0;
    endtask

    task automatic test_bypass;
        logic [DW-1:0] v = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        cycle(1, v, 1, 1, 0);
        n_checks++;
        if ({out_valid, out_last, out_data, level} !== {1'b1, 1'b1, v, 6'd1}) begin
            n_fail++;
            $display("FAIL bypass: valid=%b last=%b data=%h level=%0d, want 1 1 %h 1",
                     out_valid, out_last, out_data, level, v);
        end
        cycle(0, '0, 0, 1, 0);
        n_checks++;
        if ({out_valid, level} !== {1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL bypass_drain: valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, DW'(i), i[0], 0, 0);
            n_checks++;
            if ({level, core_hold, overflow} !== {6'(i), i >= 17, 1'b0}) begin
                n_fail++;
                $display("FAIL fill[%0d]: level=%0d hold=%b ovf=%b, want %0d %b 0",
                         i, level, core_hold, overflow, i, i >= 17);
            end
        end
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 128'd1}) begin
            n_fail++;
            $display("FAIL fill_head: valid=%b data=%h, want 1 1", out_valid, out_data);
        end
    endtask

    task automatic test_overflow;
        cycle(1, 128'hDEAD, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        n_checks++;
        if ({overflow, level} !== {1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b level=%0d, want 1 32", overflow, level);
        end
    endtask

    task automatic test_drain;
        for (int k = 1; k <= DEPTH; k++) begin
            n_checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, k[0], DW'(k)}) begin
                n_fail++;
                $display("FAIL drain[%0d]: valid=%b last=%b data=%h, want 1 %b %0d",
                         k, out_valid, out_last, out_data, k[0], k);
            end
            cycle(0, '0, 0, 1, 0);
        end
        n_checks++;
        if ({out_valid, level, overflow} !== {1'b0, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL drain_end: valid=%b level=%0d ovf=%b, want 0 0 1", out_valid, level, overflow);
        end
    endtask

    task automatic test_clear;
        for (int i = 0; i < 10; i++) cycle(1, DW'(100 + i), 0, 0, 0);
        n_checks++;
        if ({level, overflow} !== {6'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_pre: level=%0d ovf=%b, want 10 1", level, overflow);
        end
        cycle(1, 128'hBAD, 1, 1, 1);
        n_checks++;
        if ({out_valid, out_last, level, overflow} !== '0) begin
            n_fail++;
            $display("FAIL clear: valid=%b last=%b level=%0d ovf=%b, want 0 0 0 0",
                     out_valid, out_last, level, overflow);
        end
        cycle(0, '0, 0, 1, 0);
        n_checks++;
        if ({out_valid, level} !== '0) begin
            n_fail++;
            $display("FAIL clear_after: valid=%b level=%0d, want 0 0", out_valid, level);
        end
    endtask

    task automatic test_full_simul;
        for (int i = 1; i <= DEPTH; i++) cycle(1, DW'(i), 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cycle(1, DW'(33 + i), 0, 1, 0);
            n_checks++;
            if ({level, overflow, out_valid, out_data} !== {6'd32, 1'b0, 1'b1, DW'(i + 2)}) begin
                n_fail++;
                $display("FAIL full_simul[%0d]: level=%0d ovf=%b valid=%b data=%h, want 32 0 1 %0d",
                         i, level, overflow, out_valid, out_data, i + 2);
            end
        end
    endtask

    task automatic test_random;
        int pushes = 0, cyc = 0;
        bit iv, l, rdy, pv, pr, pl;
        logic [DW-1:0] d, pd;
        while (pushes < 1000 && cyc < 20000) begin
            iv = !core_hold && ($urandom % 4 != 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom);
            rdy = 1'($urandom);
            pv = out_valid; pd = out_data; pl = out_last; pr = rdy;
            cycle(iv, d, l, rdy, 0);
            cyc++;
            if (iv) pushes++;
            n_checks++;
            if ({out_valid, level, overflow, core_hold} !==
                {mq.size() > 0, 6'(mq.size()), m_ovf, (DEPTH - mq.size()) <= MARGIN}) begin
                n_fail++;
                $display("FAIL random_state[%0d]: valid=%b level=%0d ovf=%b hold=%b, want level %0d ovf %b",
                         cyc, out_valid, level, overflow, core_hold, mq.size(), m_ovf);
            end
            if (mq.size() > 0) begin
                n_checks++;
                if ({out_last, out_data} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL random_data[%0d]: got %h, want %h", cyc, {out_last, out_data}, mq[0]);
                end
            end
            if (pv && !pr) begin
                n_checks++;
                if ({out_last, out_data} !== {pl, pd}) begin
                    n_fail++;
                    $display("FAIL stall_stable[%0d]: got %h, want %h", cyc, {out_last, out_data}, {pl, pd});
                end
            end
        end
        n_checks++;
        if (pushes < 1000) begin
            n_fail++;
            $display("FAIL random_budget: pushes=%0d, want 1000 within 20000 cycles", pushes);
        end
    endtask

    task automatic test_async_reset;
        cycle(1, 128'h1234, 1, 0, 0);
        #2 rst = 0;
        #1;
        n_checks++;
        if ({out_valid, out_last, overflow, core_hold, level, out_data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b last=%b ovf=%b hold=%b level=%0d data=%h, want all 0",
                     out_valid, out_last, overflow, core_hold, level, out_data);
        end
        mq.delete(); m_ovf = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_fill();
        test_overflow();
        test_drain();
        test_clear();
        test_full_simul();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
